// File: rtl/fpu_arbiter_if.sv
// Requester-side bus of fpu_arbiter: per-requester request/operands in,
// acceptance and shared response out.
interface fpu_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_op_a;
  logic [32*N_REQ-1:0] req_op_b;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_data;
  logic [3:0]          rsp_status;
  logic [ID_W-1:0]     rsp_id;
  logic                busy;

  modport master (
    output req_valid, req_op_a, req_op_b,
    input  req_ready, rsp_valid, rsp_data, rsp_status, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b,
    output req_ready, rsp_valid, rsp_data, rsp_status, rsp_id, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one free-running FPU adder: latch the granted operands,
// hold them for a settle window, then capture and return the FPU result.
module fpu_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned SETTLE_CYCLES = 72
) (
  input  logic                clock100KHz,
  input  logic                reset,
  fpu_arbiter_if.slave        bus,
  output logic [31:0]         fpu_op_a,
  output logic [31:0]         fpu_op_b,
  input  logic [31:0]         fpu_data_in,
  input  logic [3:0]          fpu_status_in
);
  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [3:0]        rsp_status_q, rsp_status_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;

  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   idx;
  logic              grant_found;
  logic [31:0]       op_a_arr [N_REQ];
  logic [31:0]       op_b_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign op_a_arr[i] = bus.req_op_a[32*i +: 32];
    assign op_b_arr[i] = bus.req_op_b[32*i +: 32];
  end

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % N_REQ;
    return s[ID_W-1:0];
  endfunction

  // First requesting index at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant       = '0;
    idx         = '0;
    grant_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = wrap_idx(rr_ptr_q, k);
      if (!grant_found && bus.req_valid[idx]) begin
        grant       = idx;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rr_ptr_d     = rr_ptr_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    rsp_id_d     = rsp_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          op_a_d      = op_a_arr[grant];
          op_b_d      = op_b_arr[grant];
          rsp_id_d    = grant;
          req_ready_d = N_REQ'(1) << grant;
          count_d     = CntW'(SETTLE_CYCLES - 1);
          rr_ptr_d    = wrap_idx(grant, 1);
          state_d     = StWait;
        end
      end
      StWait: begin
        if (count_q == '0) begin
          rsp_data_d   = fpu_data_in;
          rsp_status_d = fpu_status_in;
          rsp_valid_d  = N_REQ'(1) << rsp_id_q;
          state_d      = StResp;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      rr_ptr_q     <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      rsp_id_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rr_ptr_q     <= rr_ptr_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      rsp_id_q     <= rsp_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.busy       = (state_q != StIdle);
  assign fpu_op_a       = op_a_q;
  assign fpu_op_b       = op_b_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: stub free-running adder, cycle-level reference model of
// grant timing/round-robin order, directed scenarios followed by random traffic.
module tb_fpu_arbiter;
  localparam int unsigned N      = 4;
  localparam int unsigned SETTLE = 72;
  localparam int unsigned PASS   = 20;

  logic        clock100KHz = 1'b0;
  logic        reset;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_data;
  logic [3:0]  fpu_status;

  fpu_arbiter_if #(.N_REQ(N)) bus ();

  fpu_arbiter #(.N_REQ(N), .SETTLE_CYCLES(SETTLE)) dut (
    .clock100KHz   (clock100KHz),
    .reset         (reset),
    .bus           (bus),
    .fpu_op_a      (fpu_op_a),
    .fpu_op_b      (fpu_op_b),
    .fpu_data_in   (fpu_data),
    .fpu_status_in (fpu_status)
  );

  always #5 clock100KHz = ~clock100KHz;

  function automatic logic [3:0] status_of(input logic [31:0] s);
    return 4'b0001 << s[1:0];
  endfunction

  // Stub adder: free-running passes of PASS cycles, result sampled at pass end.
  int unsigned pass_cnt;
  always @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      pass_cnt   <= 0;
      fpu_data   <= '0;
      fpu_status <= '0;
    end else if (pass_cnt == PASS - 1) begin
      pass_cnt   <= 0;
      fpu_data   <= fpu_op_a + fpu_op_b;
      fpu_status <= status_of(fpu_op_a + fpu_op_b);
    end else begin
      pass_cnt <= pass_cnt + 1;
    end
  end

  // Requesters
  logic [N-1:0] v_r;
  logic [31:0]  a_r [N];
  logic [31:0]  b_r [N];
  int           policy;
  bit           rand_on;

  // Reference model
  int           cyc, next_ok, resp_edge, resp_id, m_ptr, exp_id;
  logic [31:0]  resp_sum, exp_data, exp_op_a, exp_op_b;
  logic [3:0]   exp_status;
  logic [N-1:0] exp_ready, exp_rsp_valid;
  logic         exp_busy;

  int vectors, miscompares;
  int obs_g[$];
  int obs_t[$];
  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
  int fair_exp [3] = '{1, 3, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = v_r;
    for (int i = 0; i < N; i++) begin
      bus.req_op_a[32*i +: 32] = a_r[i];
      bus.req_op_b[32*i +: 32] = b_r[i];
    end
  endtask

  task automatic model_clear();
    m_ptr = 0; next_ok = 0; resp_edge = -1; resp_id = 0; resp_sum = '0;
    exp_ready = '0; exp_rsp_valid = '0; exp_data = '0; exp_status = '0;
    exp_id = 0; exp_op_a = '0; exp_op_b = '0; exp_busy = 1'b0;
  endtask

  task automatic check_all();
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_valid));
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_status", 32'(bus.rsp_status), 32'(exp_status));
    chk("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
    chk("fpu_op_a", fpu_op_a, exp_op_a);
    chk("fpu_op_b", fpu_op_b, exp_op_b);
    chk("busy", 32'(bus.busy), 32'(exp_busy));
  endtask

  task automatic do_reset(input int hold);
    v_r = '0;
    drive();
    reset = 1'b0;
    #1;
    model_clear();
    check_all();
    repeat (hold) begin
      @(posedge clock100KHz);
      cyc++;
    end
    #1 reset = 1'b1;
  endtask

  task automatic react(input int g);
    int p;
    p = policy;
    if (p == 3) p = int'($urandom_range(0, 2));
    case (p)
      1: if (policy == 3) begin a_r[g] = $urandom; b_r[g] = $urandom; end
      2: begin v_r[g] = 1'b0; a_r[g] = $urandom; end
      default: v_r[g] = 1'b0;
    endcase
  endtask

  // One clock: predict what the coming edge must produce, then compare.
  task automatic step();
    int e, g, og;
    e = cyc + 1;
    g = -1;
    exp_ready = '0;
    exp_rsp_valid = '0;
    if (e == resp_edge) begin
      exp_rsp_valid[resp_id] = 1'b1;
      exp_data   = resp_sum;
      exp_status = status_of(resp_sum);
    end
    if (e >= next_ok) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && v_r[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      exp_op_a  = a_r[g];
      exp_op_b  = b_r[g];
      exp_id    = g;
      m_ptr     = (g + 1) % N;
      resp_edge = e + SETTLE;
      resp_id   = g;
      resp_sum  = a_r[g] + b_r[g];
      next_ok   = e + SETTLE + 2;
    end
    exp_busy = (e < next_ok - 1);
    @(posedge clock100KHz);
    cyc++;
    #1;
    check_all();
    og = -1;
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) og = i;
    if (og >= 0) begin
      obs_g.push_back(og);
      obs_t.push_back(cyc);
    end
    if (g >= 0) react(g);
    if (rand_on) begin
      for (int i = 0; i < N; i++) begin
        if (!v_r[i] && $urandom_range(0, 7) == 0) begin
          v_r[i] = 1'b1;
          a_r[i] = $urandom;
          b_r[i] = $urandom;
        end
      end
    end
    drive();
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; policy = 0; rand_on = 1'b0;
    v_r = '0;
    for (int i = 0; i < N; i++) begin a_r[i] = '0; b_r[i] = '0; end
    reset = 1'b1;
    drive();
    #2;
    do_reset(2);

    // Single request from requester 2
    v_r[2] = 1'b1; a_r[2] = 32'h0400_0001; b_r[2] = 32'h0400_0001;
    drive();
    steps(SETTLE + 4);
    chk("single_data", bus.rsp_data, 32'h0800_0002);
    chk("single_status", 32'(bus.rsp_status), 32'(4'b0100));
    chk("single_id", 32'(bus.rsp_id), 32'd2);

    // Idle hold after one operation
    steps(200);

    // Reset in the middle of WAIT drops the operation
    v_r[1] = 1'b1; a_r[1] = 32'h1234_5678; b_r[1] = 32'h0000_1111;
    drive();
    steps(10);
    do_reset(2);
    steps(SETTLE + 10);

    // All four requesting continuously from reset
    do_reset(2);
    policy = 1;
    for (int i = 0; i < N; i++) begin v_r[i] = 1'b1; a_r[i] = $urandom; b_r[i] = $urandom; end
    drive();
    obs_g.delete(); obs_t.delete();
    steps(6 * (SETTLE + 2) + 2);
    for (int i = 0; i < 6; i++) begin
      chk("rr_order", (obs_g.size() > i) ? 32'(obs_g[i]) : 32'hFFFF_FFFF, 32'(rr_exp[i]));
      if (i > 0)
        chk("rr_spacing", (obs_t.size() > i) ? 32'(obs_t[i] - obs_t[i-1]) : 32'hFFFF_FFFF,
            32'(SETTLE + 2));
    end

    // Pointer fairness: 1 served, then 0 and 3 together
    do_reset(2);
    policy = 0;
    obs_g.delete(); obs_t.delete();
    v_r[1] = 1'b1; a_r[1] = 32'h0000_0010; b_r[1] = 32'h0000_0020;
    drive();
    steps(SETTLE + 8);
    v_r[0] = 1'b1; a_r[0] = 32'h0000_0100; b_r[0] = 32'h0000_0001;
    v_r[3] = 1'b1; a_r[3] = 32'h0000_0300; b_r[3] = 32'h0000_0003;
    drive();
    steps(2 * (SETTLE + 2) + 4);
    for (int i = 0; i < 3; i++)
      chk("fair_order", (obs_g.size() > i) ? 32'(obs_g[i]) : 32'hFFFF_FFFF, 32'(fair_exp[i]));

    // Operand change right after acceptance must not reach the FPU
    policy = 2;
    v_r[0] = 1'b1; a_r[0] = 32'h1111_0000; b_r[0] = 32'h0000_2222;
    drive();
    steps(SETTLE + 6);
    chk("stable_sum", bus.rsp_data, 32'h1111_2222);

    // Random traffic
    do_reset(3);
    policy = 3;
    rand_on = 1'b1;
    steps(1500);
    rand_on = 1'b0;
    v_r = '0;
    drive();
    steps(2 * SETTLE + 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
